// File: rtl/alu_register_sequencer.sv
// Instruction sequencer: queues {opcode, operand} pairs and steps a clocked
// ALU/register datapath through ALU, WRITE and READ transactions.
module alu_register_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_opcode,
    input  logic [DATA_WIDTH-1:0] in_operand,
    output logic [DATA_WIDTH-1:0] dp_opcode,
    output logic [DATA_WIDTH-1:0] dp_operand,
    output logic [DATA_WIDTH-1:0] dp_write_data,
    output logic                  dp_write_enable,
    output logic                  dp_read_enable,
    input  logic [DATA_WIDTH-1:0] dp_read_data,
    input  logic [3:0]            dp_alu_flags,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [3:0]            last_flags,
    output logic                  busy,
    output logic [15:0]           issued_count
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ALU_EXEC,
        ALU_WB,
        WRITE,
        READ,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_WRITE,
        CLS_READ
    } class_e;

    function automatic class_e decode_class(input logic [3:0] op_class);
        case (op_class)
            4'b0001: return CLS_ALU;
            4'b0010: return CLS_WRITE;
            4'b0011: return CLS_READ;
            default: return CLS_NOP;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Queue storage and instruction register are pure data: no reset.
    logic [DATA_WIDTH-1:0] fifo_opcode_q  [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_operand_q [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] instr_opcode_q, instr_opcode_d;
    logic [DATA_WIDTH-1:0] instr_operand_q, instr_operand_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [3:0]            last_flags_q, last_flags_d;
    logic [15:0]           issued_count_q, issued_count_d;

    logic [DATA_WIDTH-1:0] dp_opcode_q, dp_opcode_d;
    logic [DATA_WIDTH-1:0] dp_operand_q, dp_operand_d;
    logic [DATA_WIDTH-1:0] dp_write_data_q, dp_write_data_d;
    logic                  dp_write_enable_q, dp_write_enable_d;
    logic                  dp_read_enable_q, dp_read_enable_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  issue_done;
    class_e                head_class;

    assign full       = (count_q == FULL_CNT);
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign head_class = decode_class(fifo_opcode_q[rd_ptr_q][15:12]);

    always_comb begin
        state_d         = state_q;
        instr_opcode_d  = instr_opcode_q;
        instr_operand_d = instr_operand_q;
        rd_data_d       = rd_data_q;
        last_flags_d    = last_flags_q;
        pop             = 1'b0;
        issue_done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop             = 1'b1;
                    instr_opcode_d  = fifo_opcode_q[rd_ptr_q];
                    instr_operand_d = fifo_operand_q[rd_ptr_q];
                    case (head_class)
                        CLS_ALU:   state_d = ALU_EXEC;
                        CLS_WRITE: state_d = WRITE;
                        CLS_READ:  state_d = READ;
                        default:   issue_done = 1'b1;
                    endcase
                end
            end
            ALU_EXEC: state_d = ALU_WB;
            ALU_WB: begin
                last_flags_d = dp_alu_flags;
                issue_done   = 1'b1;
                state_d      = IDLE;
            end
            WRITE: begin
                issue_done = 1'b1;
                state_d    = IDLE;
            end
            READ: begin
                rd_data_d = dp_read_data;
                state_d   = RESP;
            end
            RESP: begin
                if (rd_ready) begin
                    issue_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d       = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d       = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d        = count_q;
        issued_count_d = issue_done ? issued_count_q + 16'd1 : issued_count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        dp_opcode_d       = '0;
        dp_operand_d      = '0;
        dp_write_data_d   = '0;
        dp_write_enable_d = 1'b0;
        dp_read_enable_d  = 1'b0;
        rd_valid_d        = 1'b0;
        if (state_d != IDLE) begin
            dp_opcode_d  = instr_opcode_d;
            dp_operand_d = instr_operand_d;
        end
        case (state_d)
            ALU_WB: dp_write_enable_d = 1'b1;
            WRITE: begin
                dp_write_enable_d = 1'b1;
                dp_write_data_d   = instr_operand_d;
            end
            READ:    dp_read_enable_d = 1'b1;
            RESP:    rd_valid_d       = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            last_flags_q      <= '0;
            issued_count_q    <= '0;
            dp_opcode_q       <= '0;
            dp_operand_q      <= '0;
            dp_write_data_q   <= '0;
            dp_write_enable_q <= 1'b0;
            dp_read_enable_q  <= 1'b0;
            rd_valid_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            last_flags_q      <= last_flags_d;
            issued_count_q    <= issued_count_d;
            dp_opcode_q       <= dp_opcode_d;
            dp_operand_q      <= dp_operand_d;
            dp_write_data_q   <= dp_write_data_d;
            dp_write_enable_q <= dp_write_enable_d;
            dp_read_enable_q  <= dp_read_enable_d;
            rd_valid_q        <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_opcode_q[wr_ptr_q]  <= in_opcode;
            fifo_operand_q[wr_ptr_q] <= in_operand;
        end
        instr_opcode_q  <= instr_opcode_d;
        instr_operand_q <= instr_operand_d;
        rd_data_q       <= rd_data_d;
    end

    assign dp_opcode       = dp_opcode_q;
    assign dp_operand      = dp_operand_q;
    assign dp_write_data   = dp_write_data_q;
    assign dp_write_enable = dp_write_enable_q;
    assign dp_read_enable  = dp_read_enable_q;
    assign rd_valid        = rd_valid_q;
    assign rd_data         = rd_data_q;
    assign last_flags      = last_flags_q;
    assign issued_count    = issued_count_q;
    assign busy            = (state_q != IDLE) || (count_q != '0);

    a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
        !(dp_write_enable && dp_read_enable));
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_q <= FULL_CNT);

endmodule

// File: tb/tb_alu_register_sequencer.sv
// Randomized scoreboard bench for alu_register_sequencer with a small
// register-file/ALU datapath model on the dp_* side.
module tb_alu_register_sequencer;

    localparam int DW = 16;
    localparam logic [1:0] K_ALU = 2'd1;
    localparam logic [1:0] K_WR  = 2'd2;
    localparam logic [1:0] K_RD  = 2'd3;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_opcode;
    logic [DW-1:0] in_operand;
    logic [DW-1:0] dp_opcode;
    logic [DW-1:0] dp_operand;
    logic [DW-1:0] dp_write_data;
    logic          dp_write_enable;
    logic          dp_read_enable;
    logic [DW-1:0] dp_read_data;
    logic [3:0]    dp_alu_flags;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [3:0]    last_flags;
    logic          busy;
    logic [15:0]   issued_count;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] opc;
        logic [15:0] opd;
        logic [15:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_mem [16];
    logic [15:0] model_issued;
    logic [15:0] dp_mem [16];
    int          compared = 0;
    int          mismatched = 0;
    bit          rdy_rand = 0;

    alu_register_sequencer #(.DATA_WIDTH(DW), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_operand(in_operand),
        .dp_opcode(dp_opcode), .dp_operand(dp_operand),
        .dp_write_data(dp_write_data),
        .dp_write_enable(dp_write_enable), .dp_read_enable(dp_read_enable),
        .dp_read_data(dp_read_data), .dp_alu_flags(dp_alu_flags),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .last_flags(last_flags), .busy(busy), .issued_count(issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [15:0] opc, input logic [15:0] opd);
        return opc[7:4] ^ opd[3:0] ^ opd[7:4];
    endfunction

    // Datapath model: register file written by WRITE ops, flags valid only on write-back.
    always @(posedge clk)
        if (dp_write_enable && dp_opcode[15:12] == 4'h2)
            dp_mem[dp_opcode[3:0]] <= dp_write_data;
    assign dp_read_data = dp_mem[dp_operand[3:0]];
    assign dp_alu_flags = dp_write_enable ? alu_f(dp_opcode, dp_operand)
                                          : ~alu_f(dp_opcode, dp_operand);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) rd_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_accept(input logic [15:0] opc, input logic [15:0] opd);
        exp_t e;
        model_issued = model_issued + 16'd1;
        e.kind = 2'd0; e.opc = opc; e.opd = opd; e.data = '0; e.flags = '0;
        case (opc[15:12])
            4'h1: begin e.kind = K_ALU; e.flags = alu_f(opc, opd); exp_q.push_back(e); end
            4'h2: begin e.kind = K_WR; e.data = opd; model_mem[opc[3:0]] = opd; exp_q.push_back(e); end
            4'h3: begin e.kind = K_RD; e.data = model_mem[opd[3:0]]; exp_q.push_back(e); end
            default: ;
        endcase
    endtask

    task automatic push(input logic [15:0] opc, input logic [15:0] opd);
        int n = 0;
        in_valid = 1'b1; in_opcode = opc; in_operand = opd;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(opc, opd);
                tick();
                break;
            end
            tick();
            n++;
            if (n > 300) begin fail_now("push_timeout"); break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic push_nops(input int count);
        int acc = 0;
        int n = 0;
        in_valid = 1'b1; in_opcode = 16'h0000;
        while (acc < count && n < count + 1000) begin
            in_operand = 16'($urandom);
            @(negedge clk);
            if (in_ready) begin
                model_accept(in_opcode, in_operand);
                acc++;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("nop_accepted", 32'(acc), 32'(count));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            tick();
            n++;
            if (n > budget) begin fail_now("idle_timeout"); break; end
        end
        check("quiesce_issued", 32'(issued_count), 32'(model_issued));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic wait_rd_valid();
        int n = 0;
        forever begin
            @(negedge clk);
            if (rd_valid) break;
            tick();
            n++;
            if (n > 20) begin fail_now("rd_valid_timeout"); break; end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_dp_opcode"}, 32'(dp_opcode), 32'd0);
        check({tag, "_dp_operand"}, 32'(dp_operand), 32'd0);
        check({tag, "_dp_wdata"}, 32'(dp_write_data), 32'd0);
        check({tag, "_strobes"}, 32'({dp_write_enable, dp_read_enable}), 32'd0);
        check({tag, "_last_flags"}, 32'(last_flags), 32'd0);
        check({tag, "_issued"}, 32'(issued_count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every datapath strobe and read response.
    initial begin : monitor
        exp_t        e;
        bit          flag_pend = 0;
        bit          rd_wait = 0;
        bit          post_hs = 0;
        logic [3:0]  flag_exp = '0;
        logic [15:0] rd_exp = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                flag_pend = 0; rd_wait = 0; post_hs = 0;
            end else begin
                if (flag_pend) begin
                    check("last_flags", 32'(last_flags), 32'(flag_exp));
                    flag_pend = 0;
                end
                if (post_hs) begin
                    check("rd_valid_drop", 32'(rd_valid), 32'd0);
                    post_hs = 0;
                end
                if (dp_write_enable || dp_read_enable) begin
                    check("strobe_excl", 32'(dp_write_enable & dp_read_enable), 32'd0);
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_strobe");
                    end else begin
                        e = exp_q.pop_front();
                        check("dp_opcode", 32'(dp_opcode), 32'(e.opc));
                        check("dp_operand", 32'(dp_operand), 32'(e.opd));
                        check("strobe_kind", 32'({dp_write_enable, dp_read_enable}),
                              (e.kind == K_RD) ? 32'd1 : 32'd2);
                        check("dp_write_data", 32'(dp_write_data),
                              (e.kind == K_WR) ? 32'(e.opd) : 32'd0);
                        if (e.kind == K_ALU) begin flag_pend = 1; flag_exp = e.flags; end
                        if (e.kind == K_RD) begin rd_wait = 1; rd_exp = e.data; end
                    end
                end else begin
                    check("wdata_idle", 32'(dp_write_data), 32'd0);
                end
                if (rd_valid) begin
                    check("rd_expected", 32'(rd_wait), 32'd1);
                    check("rd_data", 32'(rd_data), 32'(rd_exp));
                    if (rd_ready) begin rd_wait = 0; post_hs = 1; end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] opc;
        logic [3:0]  nib;
        reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_operand = '0;
        rd_ready = 1'b0; model_issued = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Fill every register so datapath and model memories agree.
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) push({12'h200, 4'(i)}, 16'($urandom));
        wait_idle(200);

        // ALU op timing: dispatch N, execute N+1, write-back N+2.
        push(16'h1003, 16'h0201);
        @(negedge clk);
        check("alu_n_dp_zero", 32'(dp_opcode), 32'd0);
        check("alu_n_busy", 32'(busy), 32'd1);
        check("alu_n_we", 32'(dp_write_enable), 32'd0);
        tick(); @(negedge clk);
        check("alu_n1_opcode", 32'(dp_opcode), 32'h1003);
        check("alu_n1_strobes", 32'({dp_write_enable, dp_read_enable}), 32'd0);
        tick(); @(negedge clk);
        check("alu_n2_we", 32'(dp_write_enable), 32'd1);
        tick(); @(negedge clk);
        check("alu_n3_we", 32'(dp_write_enable), 32'd0);
        check("alu_n3_flags", 32'(last_flags), 32'(alu_f(16'h1003, 16'h0201)));
        check("alu_n3_issued", 32'(issued_count), 32'(model_issued));
        tick();

        // WRITE op.
        push(16'h2005, 16'hBEEF);
        @(negedge clk);
        check("wr_n_we", 32'(dp_write_enable), 32'd0);
        tick(); @(negedge clk);
        check("wr_n1_we", 32'(dp_write_enable), 32'd1);
        check("wr_n1_data", 32'(dp_write_data), 32'hBEEF);
        check("wr_n1_addr", 32'(dp_opcode[3:0]), 32'd5);
        tick(); @(negedge clk);
        check("wr_n2_we", 32'(dp_write_enable), 32'd0);
        check("wr_n2_data", 32'(dp_write_data), 32'd0);
        check("wr_n2_issued", 32'(issued_count), 32'(model_issued));
        tick();

        // READ op with a stalled response.
        push(16'h2005, 16'h1234);
        wait_idle(20);
        rd_ready = 1'b0;
        push(16'h3000, 16'h0005);
        @(negedge clk);
        check("rd_n_re", 32'(dp_read_enable), 32'd0);
        tick(); @(negedge clk);
        check("rd_n1_re", 32'(dp_read_enable), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rd_hold_valid", 32'(rd_valid), 32'd1);
            check("rd_hold_data", 32'(rd_data), 32'h1234);
            tick();
        end
        rd_ready = 1'b1;
        @(negedge clk);
        check("rd_hs_valid", 32'(rd_valid), 32'd1);
        tick();
        rd_ready = 1'b0;
        @(negedge clk);
        check("rd_after_valid", 32'(rd_valid), 32'd0);
        check("rd_after_busy", 32'(busy), 32'd0);
        check("rd_after_issued", 32'(issued_count), 32'(model_issued));
        tick();

        // Fill the queue behind a stalled READ, then refill after one pop.
        push(16'h3000, 16'h0003);
        wait_rd_valid();
        tick();
        for (int i = 1; i <= 4; i++) push({12'h200, 4'(i)}, 16'($urandom));
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        rd_ready = 1'b1;
        tick();
        push(16'h1050, 16'h00A7);
        @(negedge clk);
        check("full_after_refill", 32'(in_ready), 32'd0);
        tick();
        wait_idle(100);

        // Randomized mix.
        rdy_rand = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       nib = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(4, 15));
                1:       nib = 4'h1;
                2:       nib = 4'h2;
                default: nib = 4'h3;
            endcase
            opc = {nib, 12'($urandom)};
            push(opc, 16'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle(5000);
        rdy_rand = 0;
        rd_ready = 1'b1;

        // Reset during ALU_EXEC with two entries queued behind it.
        rd_ready = 1'b0;
        push(16'h3000, 16'h0002);
        wait_rd_valid();
        tick();
        push(16'h1123, 16'h00F0);
        push(16'h3001, 16'h0003);
        push(16'h1456, 16'h0011);
        rd_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (dp_opcode == 16'h1123 && !dp_write_enable) break;
            tick();
        end
        check("exec_reached", 32'(dp_opcode), 32'h1123);
        reset = 1'b1;
        in_valid = 1'b1; in_opcode = 16'h2007; in_operand = 16'h5555;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        model_issued = '0;
        @(negedge clk);
        check_reset_state("rst_exec");
        tick(); @(negedge clk);
        check("rst_exec_we_later", 32'(dp_write_enable), 32'd0);
        check("rst_exec_busy_later", 32'(busy), 32'd0);
        tick();

        // Reset during RESP.
        rd_ready = 1'b0;
        push(16'h3000, 16'h0007);
        wait_rd_valid();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_issued = '0;
        @(negedge clk);
        check_reset_state("rst_resp");
        tick(); @(negedge clk);
        check("rst_resp_valid_later", 32'(rd_valid), 32'd0);
        tick();
        rd_ready = 1'b1;

        // issued_count wrap through a long NOP stream.
        push_nops(65535);
        wait_idle(50);
        @(negedge clk);
        check("wrap_ffff", 32'(issued_count), 32'hFFFF);
        tick();
        push(16'h0000, 16'($urandom));
        wait_idle(20);
        @(negedge clk);
        check("wrap_zero", 32'(issued_count), 32'd0);
        check("wrap_strobes", 32'({dp_write_enable, dp_read_enable}), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
